// File: rtl/VX_gpu_pkg.sv
// Shared types and sizing helpers for the result gather path.
// Default macro values let the slice compile stand-alone.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
`ifndef UP
`define UP(x) (((x) > 0) ? (x) : 1)
`endif

package VX_gpu_pkg;

   localparam int XLEN       = 32;
   localparam int UUID_WIDTH = 16;
   localparam int NW_WIDTH   = 2;
   localparam int PC_WIDTH   = 32;
   localparam int NR_WIDTH   = 5;

   typedef enum logic [1:0] {
      GATHER_IDLE    = 2'd0,
      GATHER_COLLECT = 2'd1,
      GATHER_FULL    = 2'd2
   } gather_state_e;

   typedef struct packed {
      logic [UUID_WIDTH-1:0] uuid;
      logic [NW_WIDTH-1:0]   wid;
      logic [PC_WIDTH-1:0]   PC;
      logic                  wb;
      logic [NR_WIDTH-1:0]   rd;
   } gather_hdr_t;

   function automatic int calc_num_packets(input int num_threads, input int num_lanes);
      return num_threads / num_lanes;
   endfunction

   function automatic int calc_pid_width(input int num_packets);
      return `UP(`CLOG2(num_packets));
   endfunction

endpackage

// File: rtl/VX_result_if.sv
// Writeback result bus: one beat of NUM_LANES lanes tagged with a packet id.
interface VX_result_if
   import VX_gpu_pkg::*;
#(
   parameter int NUM_LANES = 1,
   parameter int PID_WIDTH = 1
) ();

   logic                                valid;
   logic                                ready;
   logic [UUID_WIDTH-1:0]               uuid;
   logic [NW_WIDTH-1:0]                 wid;
   logic [NUM_LANES-1:0]                tmask;
   logic [PC_WIDTH-1:0]                 PC;
   logic                                wb;
   logic [NR_WIDTH-1:0]                 rd;
   logic [NUM_LANES-1:0][XLEN-1:0]      data;
   logic [PID_WIDTH-1:0]                pid;
   logic                                sop;
   logic                                eop;

   modport master (
      output valid, uuid, wid, tmask, PC, wb, rd, data, pid, sop, eop,
      input  ready
   );

   modport slave (
      input  valid, uuid, wid, tmask, PC, wb, rd, data, pid, sop, eop,
      output ready
   );

endinterface

// File: rtl/vx_gather_buffer.sv
// Warp assembly register: header plus per-slot data/tmask with a bulk clear.
// Lanes written with tmask=0 store zero so the assembled output needs no masking.
module vx_gather_buffer
   import VX_gpu_pkg::*;
#(
   parameter int NUM_LANES   = 1,
   parameter int NUM_PACKETS = 1,
   parameter int PID_WIDTH   = 1,
   localparam int NUM_THREADS = NUM_LANES * NUM_PACKETS
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             clear,
   input  logic                             hdr_we,
   input  gather_hdr_t                      hdr_in,
   input  logic                             wr_en,
   input  logic [PID_WIDTH-1:0]             wr_pid,
   input  logic [NUM_LANES-1:0]             wr_tmask,
   input  logic [NUM_LANES-1:0][XLEN-1:0]   wr_data,
   output gather_hdr_t                      hdr_out,
   output logic [NUM_THREADS-1:0]           tmask_out,
   output logic [NUM_THREADS-1:0][XLEN-1:0] data_out
);

   gather_hdr_t                      hdr_r;
   logic [NUM_THREADS-1:0]           tmask_r;
   logic [NUM_THREADS-1:0][XLEN-1:0] data_r;
   logic [NUM_PACKETS-1:0]           slot_we;

   always_comb begin
      slot_we = '0;
      for (int p = 0; p < NUM_PACKETS; p++) begin
         slot_we[p] = wr_en && (wr_pid == PID_WIDTH'(p));
      end
   end

   // A slot write wins over the clear so a sop beat lands in a freshly cleared buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         hdr_r   <= '0;
         tmask_r <= '0;
         data_r  <= '0;
      end else begin
         if (hdr_we) begin
            hdr_r <= hdr_in;
         end
         for (int p = 0; p < NUM_PACKETS; p++) begin
            if (slot_we[p]) begin
               tmask_r[p*NUM_LANES +: NUM_LANES] <= wr_tmask;
               for (int l = 0; l < NUM_LANES; l++) begin
                  data_r[p*NUM_LANES + l] <= wr_tmask[l] ? wr_data[l] : '0;
               end
            end else if (clear) begin
               tmask_r[p*NUM_LANES +: NUM_LANES] <= '0;
               for (int l = 0; l < NUM_LANES; l++) begin
                  data_r[p*NUM_LANES + l] <= '0;
               end
            end
         end
      end
   end

   assign hdr_out   = hdr_r;
   assign tmask_out = tmask_r;
   assign data_out  = data_r;

endmodule

// File: rtl/vx_result_gather.sv
// Reassembles NUM_LANES-wide result beats into one NUM_THREADS-wide commit.
// Optional macro VX_GATHER_ORDER_CHECK_EN enables the sticky order_err monitor.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
`ifndef UP
`define UP(x) (((x) > 0) ? (x) : 1)
`endif

// state   | meaning
// IDLE    | waiting for a sop beat; non-sop beats are dropped
// COLLECT | partial warp in buffer; sop restarts, eop completes
// FULL    | assembled warp presented on commit_if until accepted
module vx_result_gather
   import VX_gpu_pkg::*;
#(
   parameter     INSTANCE_ID = "",
   parameter int NUM_LANES   = 1,
   parameter int NUM_THREADS = `NUM_THREADS
) (
   input  logic          clk,
   input  logic          reset,
   VX_result_if.slave    result_if,
   VX_result_if.master   commit_if,
   output logic          order_err
);

   localparam int NUM_PACKETS = calc_num_packets(NUM_THREADS, NUM_LANES);
   localparam int PID_WIDTH   = `UP(`CLOG2(NUM_PACKETS));

   if ((NUM_THREADS % NUM_LANES) != 0) begin : g_bad_cfg
      $error("%s: NUM_THREADS must be a multiple of NUM_LANES", INSTANCE_ID);
   end

   gather_state_e state, state_n;
   logic          accept;
   logic          pid_ok;
   logic          start;
   logic          cont;
   gather_hdr_t   hdr_in;
   gather_hdr_t   hdr_out;

   assign accept = result_if.valid && result_if.ready;
   assign pid_ok = ({1'b0, result_if.pid} < (PID_WIDTH+1)'(NUM_PACKETS));
   assign start  = accept && result_if.sop && pid_ok;
   assign cont   = accept && !result_if.sop && pid_ok && (state == GATHER_COLLECT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= GATHER_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         GATHER_IDLE, GATHER_COLLECT: begin
            if (start) begin
               state_n = result_if.eop ? GATHER_FULL : GATHER_COLLECT;
            end else if (cont && result_if.eop) begin
               state_n = GATHER_FULL;
            end
         end
         GATHER_FULL: begin
            if (commit_if.ready) begin
               state_n = GATHER_IDLE;
            end
         end
         default: state_n = GATHER_IDLE;
      endcase
   end

   always_comb begin
      result_if.ready = (state != GATHER_FULL);
      commit_if.valid = (state == GATHER_FULL);
   end

   always_comb begin
      hdr_in      = '0;
      hdr_in.uuid = result_if.uuid;
      hdr_in.wid  = result_if.wid;
      hdr_in.PC   = result_if.PC;
      hdr_in.wb   = result_if.wb;
      hdr_in.rd   = result_if.rd;
   end

   vx_gather_buffer #(
      .NUM_LANES   (NUM_LANES),
      .NUM_PACKETS (NUM_PACKETS),
      .PID_WIDTH   (PID_WIDTH)
   ) buffer (
      .clk       (clk),
      .reset     (reset),
      .clear     (start),
      .hdr_we    (start),
      .hdr_in    (hdr_in),
      .wr_en     (start || cont),
      .wr_pid    (result_if.pid),
      .wr_tmask  (result_if.tmask),
      .wr_data   (result_if.data),
      .hdr_out   (hdr_out),
      .tmask_out (commit_if.tmask),
      .data_out  (commit_if.data)
   );

   assign commit_if.uuid = hdr_out.uuid;
   assign commit_if.wid  = hdr_out.wid;
   assign commit_if.PC   = hdr_out.PC;
   assign commit_if.wb   = hdr_out.wb;
   assign commit_if.rd   = hdr_out.rd;
   assign commit_if.pid  = '0;
   assign commit_if.sop  = 1'b1;
   assign commit_if.eop  = 1'b1;

`ifdef VX_GATHER_ORDER_CHECK_EN
   logic [PID_WIDTH-1:0] last_pid;
   logic                 order_err_r;
   logic                 drop;
   logic                 abandon;
   logic                 skip;

   assign drop    = accept && (!pid_ok || ((state == GATHER_IDLE) && !result_if.sop));
   assign abandon = start && (state == GATHER_COLLECT);
   assign skip    = cont && ({1'b0, result_if.pid} != ({1'b0, last_pid} + (PID_WIDTH+1)'(1)));

   always_ff @(posedge clk) begin
      if (reset) begin
         last_pid    <= '0;
         order_err_r <= 1'b0;
      end else begin
         if (start || cont) begin
            last_pid <= result_if.pid;
         end
         if (drop || abandon || skip) begin
            order_err_r <= 1'b1;
         end
      end
   end

   assign order_err = order_err_r;
`else
   assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_vx_result_gather.sv
// Directed bench for vx_result_gather: 4x1-lane gather and single-beat 4-lane gather.
module tb_vx_result_gather;
   import VX_gpu_pkg::*;

`ifdef VX_GATHER_ORDER_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic err_a, err_b;

   always #5 clk = ~clk;

   VX_result_if #(.NUM_LANES(1), .PID_WIDTH(2)) res_a ();
   VX_result_if #(.NUM_LANES(4), .PID_WIDTH(1)) com_a ();
   VX_result_if #(.NUM_LANES(4), .PID_WIDTH(1)) res_b ();
   VX_result_if #(.NUM_LANES(4), .PID_WIDTH(1)) com_b ();

   vx_result_gather #(.INSTANCE_ID("gather_a"), .NUM_LANES(1), .NUM_THREADS(4)) dut_a (
      .clk       (clk),
      .reset     (reset),
      .result_if (res_a),
      .commit_if (com_a),
      .order_err (err_a)
   );

   vx_result_gather #(.INSTANCE_ID("gather_b"), .NUM_LANES(4), .NUM_THREADS(4)) dut_b (
      .clk       (clk),
      .reset     (reset),
      .result_if (res_b),
      .commit_if (com_b),
      .order_err (err_b)
   );

   task automatic beat_a(input logic [1:0] pid, input logic [31:0] d, input logic sop,
                         input logic eop, input logic [NW_WIDTH-1:0] wid);
      chk("beat_a_ready", res_a.ready, 1'b1);
      res_a.valid = 1'b1;
      res_a.pid   = pid;
      res_a.data  = d;
      res_a.tmask = 1'b1;
      res_a.sop   = sop;
      res_a.eop   = eop;
      res_a.wid   = wid;
      res_a.uuid  = 16'h0100 + 16'(wid);
      res_a.PC    = 32'h8000_0000 | 32'(wid);
      res_a.wb    = 1'b1;
      res_a.rd    = 5'd7;
      @(posedge clk); #1;
      res_a.valid = 1'b0;
   endtask

   task automatic drain_a();
      com_a.ready = 1'b1;
      @(posedge clk); #1;
      com_a.ready = 1'b0;
      chk("drain_a_valid", com_a.valid, 1'b0);
      chk("drain_a_ready", res_a.ready, 1'b1);
   endtask

   initial begin
      res_a.valid = 1'b0; res_a.pid = '0; res_a.data = '0; res_a.tmask = '0;
      res_a.sop = 1'b0; res_a.eop = 1'b0; res_a.wid = '0; res_a.uuid = '0;
      res_a.PC = '0; res_a.wb = 1'b0; res_a.rd = '0;
      res_b.valid = 1'b0; res_b.pid = '0; res_b.data = '0; res_b.tmask = '0;
      res_b.sop = 1'b0; res_b.eop = 1'b0; res_b.wid = '0; res_b.uuid = '0;
      res_b.PC = '0; res_b.wb = 1'b0; res_b.rd = '0;
      com_a.ready = 1'b0;
      com_b.ready = 1'b0;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_ready_a", res_a.ready, 1'b1);
      chk("rst_valid_a", com_a.valid, 1'b0);
      chk("rst_err_a", err_a, 1'b0);
      chk("rst_tmask_a", com_a.tmask, 4'b0000);
      chk("rst_ready_b", res_b.ready, 1'b1);
      chk("rst_valid_b", com_b.valid, 1'b0);

      // in-order warp, 1-cycle commit latency after eop
      beat_a(2'd0, 32'h11, 1'b1, 1'b0, 2'd1);
      chk("t1_valid_pid0", com_a.valid, 1'b0);
      beat_a(2'd1, 32'h22, 1'b0, 1'b0, 2'd1);
      beat_a(2'd2, 32'h33, 1'b0, 1'b0, 2'd1);
      chk("t1_valid_pid2", com_a.valid, 1'b0);
      beat_a(2'd3, 32'h44, 1'b0, 1'b1, 2'd1);
      chk("t1_valid", com_a.valid, 1'b1);
      chk("t1_data", com_a.data, {32'h44, 32'h33, 32'h22, 32'h11});
      chk("t1_tmask", com_a.tmask, 4'b1111);
      chk("t1_wid", com_a.wid, 2'd1);
      chk("t1_uuid", com_a.uuid, 16'h0101);
      chk("t1_pc", com_a.PC, 32'h8000_0001);
      chk("t1_rd", com_a.rd, 5'd7);
      chk("t1_sop_eop_pid", {com_a.sop, com_a.eop, com_a.pid}, 3'b110);
      chk("t1_err", err_a, 1'b0);

      // backpressure on the commit side
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("t2_in_ready", res_a.ready, 1'b0);
         chk("t2_valid", com_a.valid, 1'b1);
         chk("t2_data", com_a.data, {32'h44, 32'h33, 32'h22, 32'h11});
      end
      drain_a();

      // abandon: restart on a new sop mid-warp
      beat_a(2'd0, 32'hA1, 1'b1, 1'b0, 2'd1);
      beat_a(2'd1, 32'hA2, 1'b0, 1'b0, 2'd1);
      beat_a(2'd0, 32'hB1, 1'b1, 1'b0, 2'd2);
      chk("t3_valid_abandon", com_a.valid, 1'b0);
      chk("t3_err", err_a, EXP_ERR);
      beat_a(2'd1, 32'hB2, 1'b0, 1'b0, 2'd2);
      beat_a(2'd2, 32'hB3, 1'b0, 1'b0, 2'd2);
      beat_a(2'd3, 32'hB4, 1'b0, 1'b1, 2'd2);
      chk("t3_valid", com_a.valid, 1'b1);
      chk("t3_wid", com_a.wid, 2'd2);
      chk("t3_uuid", com_a.uuid, 16'h0102);
      chk("t3_data", com_a.data, {32'hB4, 32'hB3, 32'hB2, 32'hB1});
      drain_a();

      // single-beat warp on the 4-lane instance; masked lane must read zero
      res_b.valid = 1'b1; res_b.pid = 1'b0; res_b.sop = 1'b1; res_b.eop = 1'b1;
      res_b.tmask = 4'b1011; res_b.wid = 2'd3; res_b.uuid = 16'h0BBB;
      res_b.PC = 32'h0000_1234; res_b.wb = 1'b1; res_b.rd = 5'd9;
      res_b.data = {32'hDDDD0003, 32'hDDDD0002, 32'hDDDD0001, 32'hDDDD0000};
      @(posedge clk); #1;
      res_b.valid = 1'b0;
      chk("t4_valid", com_b.valid, 1'b1);
      chk("t4_data", com_b.data, {32'hDDDD0003, 32'h0, 32'hDDDD0001, 32'hDDDD0000});
      chk("t4_tmask", com_b.tmask, 4'b1011);
      chk("t4_hdr", {com_b.uuid, com_b.wid, com_b.rd}, {16'h0BBB, 2'd3, 5'd9});
      chk("t4_in_ready", res_b.ready, 1'b0);
      chk("t4_err", err_b, 1'b0);
      com_b.ready = 1'b1;
      @(posedge clk); #1;
      com_b.ready = 1'b0;
      chk("t4_drain_valid", com_b.valid, 1'b0);
      // pid out of range on the single-packet instance is dropped
      res_b.valid = 1'b1; res_b.pid = 1'b1;
      @(posedge clk); #1;
      res_b.valid = 1'b0;
      chk("t4_oob_valid", com_b.valid, 1'b0);
      chk("t4_oob_ready", res_b.ready, 1'b1);
      chk("t4_oob_err", err_b, EXP_ERR);

      // reset mid-warp drops it silently
      beat_a(2'd0, 32'h55, 1'b1, 1'b0, 2'd0);
      beat_a(2'd1, 32'h66, 1'b0, 1'b0, 2'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("t5_rst_valid", com_a.valid, 1'b0);
      chk("t5_rst_tmask", com_a.tmask, 4'b0000);
      chk("t5_rst_err", err_a, 1'b0);
      chk("t5_rst_ready", res_a.ready, 1'b1);
      @(posedge clk); #1;
      chk("t5_no_commit", com_a.valid, 1'b0);
      beat_a(2'd0, 32'hC1, 1'b1, 1'b0, 2'd3);
      beat_a(2'd1, 32'hC2, 1'b0, 1'b0, 2'd3);
      beat_a(2'd2, 32'hC3, 1'b0, 1'b0, 2'd3);
      beat_a(2'd3, 32'hC4, 1'b0, 1'b1, 2'd3);
      chk("t5_valid", com_a.valid, 1'b1);
      chk("t5_data", com_a.data, {32'hC4, 32'hC3, 32'hC2, 32'hC1});
      chk("t5_tmask", com_a.tmask, 4'b1111);
      chk("t5_err", err_a, 1'b0);
      drain_a();

      // skipped pid leaves a zero hole
      beat_a(2'd0, 32'hE1, 1'b1, 1'b0, 2'd1);
      beat_a(2'd2, 32'hE3, 1'b0, 1'b0, 2'd1);
      beat_a(2'd3, 32'hE4, 1'b0, 1'b1, 2'd1);
      chk("t6_valid", com_a.valid, 1'b1);
      chk("t6_tmask", com_a.tmask, 4'b1101);
      chk("t6_data", com_a.data, {32'hE4, 32'hE3, 32'h0, 32'hE1});
      chk("t6_err", err_a, EXP_ERR);
      drain_a();

      // non-sop beat in IDLE is dropped, eop included
      beat_a(2'd3, 32'h77, 1'b0, 1'b1, 2'd1);
      chk("t7_drop_valid", com_a.valid, 1'b0);
      chk("t7_drop_ready", res_a.ready, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
